// File: rtl/spi_rd_master.sv
// spi_rd_master: SPI mode-0 read initiator for the 5-bit-address /
// 16-bit-data ROM responder. A transaction is 51 equal-length phases:
// PRE_L, PRE_H (CS-high sck edge resynchronises the responder), SEL,
// then 24 sck periods (48 phases), then a single FIN cycle with done.
module spi_rd_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  addr_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_o,
    output logic        sck_o,
    output logic        cs_n_o,
    output logic        sdi_o,
    input  logic        sdo_i
);

    localparam int unsigned DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_L,
        ST_PRE_H,
        ST_SEL,
        ST_SHIFT,
        ST_FIN
    } state_t;

    state_t          r_state;
    logic [DIVW-1:0] r_div;
    logic            r_hi;
    logic [4:0]      r_k;
    logic [4:0]      r_addr;
    logic [15:0]     r_shift;
    logic            w_phase_end;

    assign w_phase_end = (r_div == DIV_LAST);

    // Sequencer: phase timing, sck/cs generation, address shift-out, data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_hi    <= 1'b0;
            r_k     <= '0;
            r_addr  <= '0;
            r_shift <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data_o  <= '0;
            sck_o   <= 1'b0;
            cs_n_o  <= 1'b1;
            sdi_o   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || (r_state == ST_FIN) || w_phase_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= addr_i;
                        busy    <= 1'b1;
                        sdi_o   <= 1'b0;
                        r_state <= ST_PRE_L;
                    end
                end
                ST_PRE_L: begin
                    if (w_phase_end) begin
                        sck_o   <= 1'b1;
                        r_state <= ST_PRE_H;
                    end
                end
                ST_PRE_H: begin
                    if (w_phase_end) begin
                        sck_o   <= 1'b0;
                        cs_n_o  <= 1'b0;
                        r_state <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (w_phase_end) begin
                        sck_o   <= 1'b1;
                        r_hi    <= 1'b1;
                        r_k     <= 5'd1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        if (r_hi) begin
                            // Falling edge after edge k presents the bit the responder samples at edge k+1.
                            sck_o <= 1'b0;
                            r_hi  <= 1'b0;
                            if (r_k <= 5'd5) begin
                                sdi_o  <= r_addr[4];
                                r_addr <= {r_addr[3:0], 1'b0};
                            end else begin
                                sdi_o <= 1'b0;
                            end
                        end else if (r_k == 5'd24) begin
                            cs_n_o  <= 1'b1;
                            done    <= 1'b1;
                            data_o  <= r_shift;
                            r_state <= ST_FIN;
                        end else begin
                            // Sample the pin before the responder updates it on this rising edge.
                            sck_o <= 1'b1;
                            r_hi  <= 1'b1;
                            r_k   <= r_k + 5'd1;
                            if (r_k >= 5'd8) begin
                                r_shift <= {r_shift[14:0], sdo_i};
                            end
                        end
                    end
                end
                ST_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rd_master.sv
// tb_spi_rd_master: two initiators (CLK_DIV=2 and CLK_DIV=1), each wired to a
// behavioural model of the SPI ROM responder. Expected words come from the
// bench's own ROM image; timing comes from the 51-phase transaction length.
module tb_spi_rd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        start [2];
    logic [4:0]  addr  [2];
    logic        busy  [2];
    logic        done  [2];
    logic [15:0] data  [2];
    logic        sck   [2];
    logic        csn   [2];
    logic        sdi   [2];
    logic        sdo   [2];

    int unsigned dv [2] = '{2, 1};

    spi_rd_master #(.CLK_DIV(2)) u_dut_d2 (
        .clk(clk), .rst(rst), .start(start[0]), .addr_i(addr[0]),
        .busy(busy[0]), .done(done[0]), .data_o(data[0]),
        .sck_o(sck[0]), .cs_n_o(csn[0]), .sdi_o(sdi[0]), .sdo_i(sdo[0])
    );

    spi_rd_master #(.CLK_DIV(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .start(start[1]), .addr_i(addr[1]),
        .busy(busy[1]), .done(done[1]), .data_o(data[1]),
        .sck_o(sck[1]), .cs_n_o(csn[1]), .sdi_o(sdi[1]), .sdo_i(sdo[1])
    );

    // Responder model and bus observers
    logic [15:0] rom [2][32];
    logic        force_hi [2] = '{1'b0, 1'b0};
    int          n        [2] = '{0, 0};
    logic [4:0]  ra       [2] = '{5'd0, 5'd0};
    logic [15:0] w        [2] = '{16'd0, 16'd0};
    logic        drv      [2] = '{1'b0, 1'b0};
    logic        prev_sck [2] = '{1'b0, 1'b0};
    int          cshi     [2] = '{0, 0};
    int          cslo     [2] = '{0, 0};
    int          sdi_bad  [2] = '{0, 0};
    int          hi_bad   [2] = '{0, 0};
    int          hirun    [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i]) done_cnt[i]++;
            if (sck[i]) hirun[i]++;
            if (prev_sck[i] && !sck[i]) begin
                if (hirun[i] != int'(dv[i])) hi_bad[i]++;
                hirun[i] = 0;
            end
            if (!prev_sck[i] && sck[i]) begin
                if (csn[i]) begin
                    n[i] = 0;
                    cshi[i]++;
                end else begin
                    n[i]++;
                    cslo[i]++;
                    if (n[i] >= 2 && n[i] <= 6) ra[i] = {ra[i][3:0], sdi[i]};
                    else if (sdi[i] !== 1'b0) sdi_bad[i]++;
                    if (n[i] == 7) w[i] = rom[i][ra[i]];
                    if (n[i] >= 8 && n[i] <= 23) drv[i] = w[i][23 - n[i]];
                end
            end
            prev_sck[i] = sck[i];
            sdo[i] = (force_hi[i] && n[i] < 9) ? 1'b1 : drv[i];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input int i, input logic [4:0] a, input logic [15:0] expd,
                           input bit hold, input bit noise);
        int t0;
        int b_hi, b_lo, b_sb, b_hb, b_dn;
        bit seen;
        int lim;
        b_hi = cshi[i]; b_lo = cslo[i]; b_sb = sdi_bad[i]; b_hb = hi_bad[i]; b_dn = done_cnt[i];
        start[i] = 1'b1;
        addr[i]  = a;
        t0   = cyc;
        seen = 1'b0;
        lim  = 51 * int'(dv[i]) + 20;
        for (int k = 0; k < lim && !seen; k++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1'b1;
            end else if (!hold) begin
                if (noise && (cyc - t0 == 10 || cyc - t0 == 40)) start[i] = 1'b1;
                else start[i] = 1'b0;
                if (noise) addr[i] = ~a;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc - t0), 32'(51 * dv[i] + 1));
        chk("data", 32'(data[i]), 32'(expd));
        chk("rx_addr", 32'(ra[i]), 32'(a));
        chk("cs_hi_edges", 32'(cshi[i] - b_hi), 32'd1);
        chk("cs_lo_edges", 32'(cslo[i] - b_lo), 32'd24);
        chk("sdi_idle_zero", 32'(sdi_bad[i] - b_sb), 32'd0);
        chk("sck_hi_len", 32'(hi_bad[i] - b_hb), 32'd0);
        @(negedge clk);
        chk("busy_drop", 32'(busy[i]), 32'd0);
        chk("done_once", 32'(done_cnt[i] - b_dn), 32'd1);
        chk("data_hold", 32'(data[i]), 32'(expd));
        if (!hold) start[i] = 1'b0;
    endtask

    initial begin
        logic [4:0]  ra_rnd;
        logic [15:0] wd;
        int          b_dn;
        int          idx;
        bit          nz;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            addr[i]  = '0;
            for (int a = 0; a < 32; a++) rom[i][a] = 16'(a * 257);
        end
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(csn[0]), 32'd1);
        chk("rst_sck", 32'(sck[0]), 32'd0);
        chk("rst_sdi", 32'(sdi[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_data", 32'(data[0]), 32'd0);
        chk("rst_cs_n_d1", 32'(csn[1]), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single read at CLK_DIV=2
        do_read(0, 5'h15, 16'h1515, 1'b0, 1'b0);

        // Back-to-back at CLK_DIV=1 with start held high
        do_read(1, 5'h00, 16'h0000, 1'b1, 1'b0);
        do_read(1, 5'h1F, 16'h1F1F, 1'b0, 1'b0);

        // Start pulses and address changes during a transaction are ignored
        do_read(0, 5'h0C, 16'h0C0C, 1'b0, 1'b1);
        do_read(1, 5'h13, 16'h1313, 1'b0, 1'b1);

        // Reset after edge 12
        b_dn = done_cnt[0];
        start[0] = 1'b1;
        addr[0]  = 5'h07;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!csn[0] && n[0] >= 12) break;
            @(negedge clk);
        end
        chk("rst_mid_reached", 32'(n[0] >= 12), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_cs_n", 32'(csn[0]), 32'd1);
        chk("rst_mid_sck", 32'(sck[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_data", 32'(data[0]), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt[0] - b_dn), 32'd0);
        do_read(0, 5'h0A, 16'h0A0A, 1'b0, 1'b0);

        // Bit ordering
        rom[0][3] = 16'h8001;
        do_read(0, 5'h03, 16'h8001, 1'b0, 1'b0);
        rom[0][4] = 16'h0000;
        force_hi[0] = 1'b1;
        do_read(0, 5'h04, 16'h8000, 1'b0, 1'b0);
        force_hi[0] = 1'b0;

        // Randomized reads with random ROM contents
        for (int r = 0; r < 8; r++) begin
            idx    = int'($urandom_range(0, 1));
            ra_rnd = 5'($urandom);
            wd     = 16'($urandom);
            nz     = 1'($urandom);
            rom[idx][ra_rnd] = wd;
            do_read(idx, ra_rnd, wd, 1'b0, nz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
